// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: field formats, error codes,
// FSM states, the beat payload struct and an immediate range helper.
package inst_encoder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_FMT      = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef struct packed {
    fmt_e              fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [WORD_W-1:0] imm;
  } inst_fields_t;

  // True when imm is representable as an n-bit two's-complement value,
  // i.e. imm[31:n-1] are all equal.
  function automatic logic fits_signed(input logic [WORD_W-1:0] imm,
                                       input int unsigned n);
    logic [WORD_W-1:0] t;
    t = WORD_W'($signed(imm) >>> (n - 1));
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer with immediate range checking.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  inst_fields_t       fields,
  output logic [WORD_W-1:0]  word_c,
  output err_e               err_c
);

  logic [WORD_W-1:0] imm;
  assign imm = fields.imm;

  always_comb begin
    word_c = '0;
    err_c  = ERR_NONE;
    case (fields.fmt)
      FMT_R: begin
        word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      end
      FMT_I: begin
        word_c = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        if (!fits_signed(imm, 12)) err_c = ERR_RANGE;
      end
      FMT_ISH: begin
        word_c = {fields.funct7, imm[4:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        if (imm[31:5] != '0) err_c = ERR_RANGE;
      end
      FMT_S: begin
        word_c = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        if (!fits_signed(imm, 12)) err_c = ERR_RANGE;
      end
      FMT_B: begin
        word_c = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                  imm[4:1], imm[11], fields.opcode};
        if (!fits_signed(imm, 13) || imm[0]) err_c = ERR_RANGE;
      end
      FMT_U: begin
        word_c = {imm[31:12], fields.rd, fields.opcode};
        if (imm[11:0] != '0) err_c = ERR_RANGE;
      end
      FMT_J: begin
        word_c = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        if (!fits_signed(imm, 21) || imm[0]) err_c = ERR_RANGE;
      end
      default: begin
        err_c = ERR_FMT;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streams instruction fields in, packs them into RV32I words and writes them
// sequentially into IMEM; any bad beat aborts the session into ERROR.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   inst_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state, state_d;
  err_e              err_q, err_d;
  logic              wr_d;
  logic              clr_d;
  logic              accept;
  inst_fields_t      fields;
  logic [WORD_W-1:0] pack_word;
  err_e              pack_err;

  assign fields = '{
    fmt:    fmt_e'(in_fmt),
    opcode: in_opcode,
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    funct3: in_funct3,
    funct7: in_funct7,
    imm:    in_imm
  };

  inst_pack u_pack (
    .fields (fields),
    .word_c (pack_word),
    .err_c  (pack_err)
  );

  assign accept   = in_valid && in_ready;
  assign err_code = err_q;

  // Next-state, write request and error capture
  always_comb begin
    state_d = state;
    err_d   = err_q;
    wr_d    = 1'b0;
    clr_d   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          err_d   = ERR_NONE;
          clr_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pack_err != ERR_NONE) begin
            state_d = ST_ERROR;
            err_d   = pack_err;
          end else if (inst_count == CNT_W'(IMEM_DEPTH)) begin
            state_d = ST_ERROR;
            err_d   = ERR_OVERFLOW;
          end else begin
            wr_d = 1'b1;
            if (in_last) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, status flags and the single-cycle IMEM write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      err_q      <= ERR_NONE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      inst_count <= '0;
    end else begin
      state    <= state_d;
      err_q    <= err_d;
      in_ready <= (state_d == ST_LOAD);
      busy     <= (state_d == ST_LOAD);
      done     <= (state_d == ST_DONE);
      err      <= (state_d == ST_ERROR);
      imem_we  <= wr_d;
      if (wr_d) begin
        imem_addr  <= ADDR_W'(BASE_ADDR) + inst_count[ADDR_W-1:0];
        imem_wdata <= pack_word;
      end
      if (clr_d) begin
        inst_count <= '0;
      end else if (wr_d) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

endmodule
